// File: rtl/alu_share_arb.sv
// alu_share_arb: lets two requesters share one external combinational ALU.
// A three-state FSM (IDLE -> EXEC -> RESP) keeps at most one operation in
// flight. The winning request is latched on acceptance, replayed onto the
// ALU for exactly one cycle, and the ALU result is captured and held until
// the owning requester takes it.
//
// Build option:
//   ALU_SHARE_ARB_RR_EN  - when defined, simultaneous requests are resolved
//                          round-robin with a 1-bit pointer. When undefined,
//                          requester 0 always wins a tie and no pointer
//                          register is built.

module alu_share_arb (
    input  logic        clk,
    input  logic        rst,

    // Requester 0
    input  logic        req_valid_0,
    output logic        req_ready_0,
    input  logic [1:0]  req_alu_op_0,
    input  logic [5:0]  req_funct_0,
    input  logic [31:0] req_a_0,
    input  logic [31:0] req_b_0,
    output logic        resp_valid_0,
    input  logic        resp_ready_0,

    // Requester 1
    input  logic        req_valid_1,
    output logic        req_ready_1,
    input  logic [1:0]  req_alu_op_1,
    input  logic [5:0]  req_funct_1,
    input  logic [31:0] req_a_1,
    input  logic [31:0] req_b_1,
    output logic        resp_valid_1,
    input  logic        resp_ready_1,

    // Shared response
    output logic [31:0] resp_data,
    output logic        resp_zero,

    // Shared ALU
    output logic [1:0]  alu_op,
    output logic [5:0]  funct,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic        alu_zero
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_next;

    // Captured operation; owner_q is 0 for requester 0, 1 for requester 1
    logic [1:0]  op_q;
    logic [5:0]  funct_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        owner_q;

    // Arbitration and handshake terms
    logic        grant_0;
    logic        grant_1;
    logic        in_idle;
    logic        accept;
    logic        accept_id;
    logic        owner_ready;

    // Fields of the request being accepted this cycle
    logic [1:0]  sel_op;
    logic [5:0]  sel_funct;
    logic [31:0] sel_a;
    logic [31:0] sel_b;

`ifdef ALU_SHARE_ARB_RR_EN
    // Pointer value names the requester that wins the next tie
    logic        rr_ptr;

    // Round-robin tie break: a lone requester always wins, a tie goes to rr_ptr
    always_comb begin
        grant_0 = 1'b0;
        grant_1 = 1'b0;
        if (req_valid_0 && req_valid_1) begin
            grant_0 = ~rr_ptr;
            grant_1 = rr_ptr;
        end else begin
            grant_0 = req_valid_0;
            grant_1 = req_valid_1;
        end
    end

    // Point at the requester that was not just granted, on every acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (accept) begin
            rr_ptr <= ~accept_id;
        end
    end
`else
    // Fixed priority: requester 0 wins every tie
    always_comb begin
        grant_0 = req_valid_0;
        grant_1 = req_valid_1 & ~req_valid_0;
    end
`endif

    // Ready is offered only in IDLE and never while reset is asserted
    always_comb begin
        in_idle     = (state == IDLE) && !rst;
        req_ready_0 = in_idle && grant_0;
        req_ready_1 = in_idle && grant_1;
        accept      = req_ready_0 || req_ready_1;
        accept_id   = req_ready_1;
    end

    // Steer the accepted requester's fields toward the capture registers
    always_comb begin
        if (accept_id) begin
            sel_op    = req_alu_op_1;
            sel_funct = req_funct_1;
            sel_a     = req_a_1;
            sel_b     = req_b_1;
        end else begin
            sel_op    = req_alu_op_0;
            sel_funct = req_funct_0;
            sel_a     = req_a_0;
            sel_b     = req_b_0;
        end
    end

    // Only the owner's resp_ready can retire the response
    always_comb begin
        owner_ready = owner_q ? resp_ready_1 : resp_ready_0;
    end

    // Next-state logic; RESP always returns through IDLE so no new request
    // can be accepted in the handshake cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                if (owner_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; reset abandons any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the accepted operation so later requester activity cannot disturb it
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= 2'd0;
            funct_q <= 6'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            owner_q <= 1'b0;
        end else if (accept) begin
            op_q    <= sel_op;
            funct_q <= sel_funct;
            a_q     <= sel_a;
            b_q     <= sel_b;
            owner_q <= accept_id;
        end
    end

    // Capture the ALU outputs at the end of the EXEC cycle and hold them
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_data <= 32'd0;
            resp_zero <= 1'b0;
        end else if (state == EXEC) begin
            resp_data <= alu_result;
            resp_zero <= alu_zero;
        end
    end

    // Drive the shared ALU only during EXEC so it sees zeros otherwise
    always_comb begin
        if (state == EXEC) begin
            alu_op = op_q;
            funct  = funct_q;
            alu_a  = a_q;
            alu_b  = b_q;
        end else begin
            alu_op = 2'd0;
            funct  = 6'd0;
            alu_a  = 32'd0;
            alu_b  = 32'd0;
        end
    end

    // Response valid goes only to the owner, and is masked while in reset
    always_comb begin
        resp_valid_0 = !rst && (state == RESP) && !owner_q;
        resp_valid_1 = !rst && (state == RESP) &&  owner_q;
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed bench for alu_share_arb with a scoreboard.
// Drivers push the hand-computed expected result per requester on
// acceptance; a monitor pops and compares on every response handshake and
// logs the grant order. A simple combinational ALU stands in for the
// shared ALU. Honors ALU_SHARE_ARB_RR_EN for the expected grant order.

module tb_alu_share_arb;

    logic        clk;
    logic        rst;

    logic        req_valid_0, req_ready_0, resp_valid_0, resp_ready_0;
    logic [1:0]  req_alu_op_0;
    logic [5:0]  req_funct_0;
    logic [31:0] req_a_0, req_b_0;

    logic        req_valid_1, req_ready_1, resp_valid_1, resp_ready_1;
    logic [1:0]  req_alu_op_1;
    logic [5:0]  req_funct_1;
    logic [31:0] req_a_1, req_b_1;

    logic [31:0] resp_data;
    logic        resp_zero;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_zero;

    int          errors;
    int          checks;

    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];
    int          grant_log[$];
    logic [32:0] mon_e0;
    logic [32:0] mon_e1;

    alu_share_arb dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_0  (req_valid_0),
        .req_ready_0  (req_ready_0),
        .req_alu_op_0 (req_alu_op_0),
        .req_funct_0  (req_funct_0),
        .req_a_0      (req_a_0),
        .req_b_0      (req_b_0),
        .resp_valid_0 (resp_valid_0),
        .resp_ready_0 (resp_ready_0),
        .req_valid_1  (req_valid_1),
        .req_ready_1  (req_ready_1),
        .req_alu_op_1 (req_alu_op_1),
        .req_funct_1  (req_funct_1),
        .req_a_1      (req_a_1),
        .req_b_1      (req_b_1),
        .resp_valid_1 (resp_valid_1),
        .resp_ready_1 (resp_ready_1),
        .resp_data    (resp_data),
        .resp_zero    (resp_zero),
        .alu_op       (alu_op),
        .funct        (funct),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in shared ALU: 00 add, 01 sub, 10 decode funct (MIPS style)
    always_comb begin
        alu_result = 32'd0;
        case (alu_op)
            2'b00: alu_result = alu_a + alu_b;
            2'b01: alu_result = alu_a - alu_b;
            2'b10: begin
                case (funct)
                    6'h20: alu_result = alu_a + alu_b;
                    6'h22: alu_result = alu_a - alu_b;
                    6'h24: alu_result = alu_a & alu_b;
                    6'h25: alu_result = alu_a | alu_b;
                    6'h2a: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
                    default: alu_result = 32'd0;
                endcase
            end
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    // Single comparison point: counts every check and reports failures
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Present one request, wait (bounded) for acceptance, push expectation
    task automatic applyStimulus(input int id, input logic [1:0] op,
                                 input logic [5:0] fn, input logic [31:0] a,
                                 input logic [31:0] b,
                                 input logic [31:0] exp_data,
                                 input logic exp_zero, input bit expect_resp);
        bit accepted;
        accepted = 1'b0;
        if (id == 0) begin
            req_valid_0 = 1'b1; req_alu_op_0 = op; req_funct_0 = fn;
            req_a_0 = a; req_b_0 = b;
        end else begin
            req_valid_1 = 1'b1; req_alu_op_1 = op; req_funct_1 = fn;
            req_a_1 = a; req_b_1 = b;
        end
        for (int c = 0; c < 100 && !accepted; c++) begin
            @(negedge clk);
            if ((id == 0) ? req_ready_0 : req_ready_1) begin
                accepted = 1'b1;
                if (expect_resp) begin
                    if (id == 0) exp_q0.push_back({exp_zero, exp_data});
                    else         exp_q1.push_back({exp_zero, exp_data});
                end
            end
        end
        checkOutput($sformatf("accept_req%0d", id), 32'(accepted), 32'd1);
        @(posedge clk);
        #1;
        // Scramble the inputs so a design that re-reads them gets caught
        if (id == 0) begin
            req_valid_0 = 1'b0; req_alu_op_0 = ~op; req_funct_0 = ~fn;
            req_a_0 = ~a; req_b_0 = ~b;
        end else begin
            req_valid_1 = 1'b0; req_alu_op_1 = ~op; req_funct_1 = ~fn;
            req_a_1 = ~a; req_b_1 = ~b;
        end
    endtask

    // Bounded wait for resp_valid of a requester; returns at that negedge
    task automatic waitResp(input int id);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if ((id == 0) ? resp_valid_0 : resp_valid_1) seen = 1'b1;
        end
        checkOutput($sformatf("resp_valid_seen%0d", id), 32'(seen), 32'd1);
    endtask

    // Bounded wait until the scoreboard is empty; returns after the next edge
    task automatic drainScoreboard(input string name);
        for (int c = 0; c < 60 && (exp_q0.size() + exp_q1.size()) != 0; c++) begin
            @(negedge clk);
        end
        checkOutput(name, 32'(exp_q0.size() + exp_q1.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: per-cycle exclusivity, grant logging and response scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("resp_valid_onehot", 32'(resp_valid_0 & resp_valid_1), 32'd0);
            if (req_valid_0 && req_ready_0) grant_log.push_back(0);
            if (req_valid_1 && req_ready_1) grant_log.push_back(1);
            if (resp_valid_0 && resp_ready_0) begin
                if (exp_q0.size() == 0) begin
                    checkOutput("resp0_expected_pending", 32'(exp_q0.size()), 32'd1);
                end else begin
                    mon_e0 = exp_q0.pop_front();
                    checkOutput("resp0_data", resp_data, mon_e0[31:0]);
                    checkOutput("resp0_zero", 32'(resp_zero), 32'(mon_e0[32]));
                end
            end
            if (resp_valid_1 && resp_ready_1) begin
                if (exp_q1.size() == 0) begin
                    checkOutput("resp1_expected_pending", 32'(exp_q1.size()), 32'd1);
                end else begin
                    mon_e1 = exp_q1.pop_front();
                    checkOutput("resp1_data", resp_data, mon_e1[31:0]);
                    checkOutput("resp1_zero", 32'(resp_zero), 32'(mon_e1[32]));
                end
            end
        end
    end

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence
    initial begin
        int exp_grants[8];
        errors = 0;
        checks = 0;
        rst = 1'b1;
        req_valid_0 = 1'b1; req_alu_op_0 = 2'd0; req_funct_0 = 6'd0;
        req_a_0 = 32'd1; req_b_0 = 32'd1;
        req_valid_1 = 1'b1; req_alu_op_1 = 2'd0; req_funct_1 = 6'd0;
        req_a_1 = 32'd1; req_b_1 = 32'd1;
        resp_ready_0 = 1'b1;
        resp_ready_1 = 1'b1;

        // Reset with both requesters valid: nothing may be offered
        repeat (3) begin
            @(negedge clk);
            checkOutput("rst_req_ready_0", 32'(req_ready_0), 32'd0);
            checkOutput("rst_req_ready_1", 32'(req_ready_1), 32'd0);
            checkOutput("rst_resp_valid_0", 32'(resp_valid_0), 32'd0);
            checkOutput("rst_resp_valid_1", 32'(resp_valid_1), 32'd0);
            checkOutput("rst_resp_data", resp_data, 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        @(negedge clk);
        checkOutput("idle_alu_a", alu_a, 32'd0);
        checkOutput("idle_alu_op", 32'(alu_op), 32'd0);
        checkOutput("idle_resp_zero", 32'(resp_zero), 32'd0);
        @(posedge clk);
        #1;

        // Requester 0 add 5+7: EXEC drives the ALU, then RESP shows 12
        applyStimulus(0, 2'b00, 6'd0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("exec_alu_a", alu_a, 32'd5);
        checkOutput("exec_alu_b", alu_b, 32'd7);
        checkOutput("exec_resp_valid_0", 32'(resp_valid_0), 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("t1_resp_valid_0", 32'(resp_valid_0), 32'd1);
        checkOutput("t1_resp_data", resp_data, 32'd12);
        checkOutput("t1_resp_zero", 32'(resp_zero), 32'd0);
        @(posedge clk);
        #1;

        // Requester 1 sub 9-9: zero result, requester 0 stays quiet
        applyStimulus(1, 2'b01, 6'd0, 32'd9, 32'd9, 32'd0, 1'b1, 1'b1);
        waitResp(1);
        checkOutput("t2_resp_valid_0", 32'(resp_valid_0), 32'd0);
        checkOutput("t2_resp_data", resp_data, 32'd0);
        checkOutput("t2_resp_zero", 32'(resp_zero), 32'd1);
        @(posedge clk);
        #1;

        // Backpressure on requester 0 while requester 1 waits
        resp_ready_0 = 1'b0;
        applyStimulus(0, 2'b10, 6'h24, 32'h0000_F0F0, 32'h0000_FF00,
                      32'h0000_F000, 1'b0, 1'b1);
        fork
            begin
                applyStimulus(1, 2'b00, 6'd0, 32'd1, 32'd1, 32'd2, 1'b0, 1'b1);
            end
            begin
                @(negedge clk);
                checkOutput("bp_exec_req_ready_1", 32'(req_ready_1), 32'd0);
                @(posedge clk);
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    checkOutput("bp_resp_valid_0", 32'(resp_valid_0), 32'd1);
                    checkOutput("bp_resp_data", resp_data, 32'h0000_F000);
                    checkOutput("bp_req_ready_1", 32'(req_ready_1), 32'd0);
                    @(posedge clk);
                    #1;
                end
                resp_ready_0 = 1'b1;
                @(negedge clk);
                checkOutput("bp_hs_req_ready_1", 32'(req_ready_1), 32'd0);
                @(posedge clk);
                @(negedge clk);
                checkOutput("bp_after_req_ready_1", 32'(req_ready_1), 32'd1);
            end
        join
        drainScoreboard("bp_drain");

        // Reset during EXEC abandons the operation
        applyStimulus(0, 2'b00, 6'd0, 32'd40, 32'd2, 32'd42, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rexec_req_ready_0", 32'(req_ready_0), 32'd0);
        checkOutput("rexec_resp_valid_0", 32'(resp_valid_0), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checkOutput("rexec_quiet_0", 32'(resp_valid_0), 32'd0);
            checkOutput("rexec_quiet_1", 32'(resp_valid_1), 32'd0);
        end
        checkOutput("rexec_resp_data", resp_data, 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(1, 2'b00, 6'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1'b1);
        drainScoreboard("rexec_drain");

        // Both requesters valid back to back, four operations each
        grant_log.delete();
        fork
            begin
                applyStimulus(0, 2'b00, 6'd0,  32'd10, 32'd20, 32'd30, 1'b0, 1'b1);
                applyStimulus(0, 2'b10, 6'h25, 32'h0F, 32'hF0, 32'hFF, 1'b0, 1'b1);
                applyStimulus(0, 2'b01, 6'd0,  32'd100, 32'd1, 32'd99, 1'b0, 1'b1);
                applyStimulus(0, 2'b10, 6'h2a, 32'd3, 32'd5, 32'd1, 1'b0, 1'b1);
            end
            begin
                applyStimulus(1, 2'b00, 6'd0,  32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b1);
                applyStimulus(1, 2'b01, 6'd0,  32'd50, 32'd8, 32'd42, 1'b0, 1'b1);
                applyStimulus(1, 2'b10, 6'h24, 32'hFF, 32'h0F, 32'h0F, 1'b0, 1'b1);
                applyStimulus(1, 2'b10, 6'h22, 32'd7, 32'd7, 32'd0, 1'b1, 1'b1);
            end
        join
        drainScoreboard("both_drain");

`ifdef ALU_SHARE_ARB_RR_EN
        exp_grants = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
        exp_grants = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
        checkOutput("grant_count", 32'(grant_log.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("grant_order_%0d", i),
                        (i < grant_log.size()) ? 32'(grant_log[i]) : 32'hFFFF_FFFF,
                        32'(exp_grants[i]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 The block SHALL have the port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port `rst`, input, 1 bit: synchronous, active-high reset.
REQ-003 For each requester i in {0,1}, the block SHALL have the port `req_valid_i`, input, 1 bit: requester i presents an operation.
REQ-004 For each requester i, the block SHALL have the port `req_ready_i`, output, 1 bit: the operation from requester i is accepted this cycle.
REQ-005 For each requester i, the block SHALL have the ports `req_alu_op_i` (input, 2 bits) and `req_funct_i` (input, 6 bits): the ALU control encoding (00 add, 01 sub, 10 use funct).
REQ-006 For each requester i, the block SHALL have the ports `req_a_i` and `req_b_i`, input, 32 bits each: the operands.
REQ-007 For each requester i, the block SHALL have the port `resp_valid_i`, output, 1 bit: a result for requester i is available.
REQ-008 For each requester i, the block SHALL have the port `resp_ready_i`, input, 1 bit: requester i consumes the result.
REQ-009 The block SHALL have the ports `resp_data`, output, 32 bits, and `resp_zero`, output, 1 bit: the captured result and zero flag, shared by both requesters.
REQ-010 The block SHALL have the ports `alu_op`, output, 2 bits; `funct`, output, 6 bits; `alu_a` and `alu_b`, output, 32 bits each: drive the shared ALU control and ALU.
REQ-011 The block SHALL have the ports `alu_result`, input, 32 bits, and `alu_zero`, input, 1 bit: combinational outputs of the shared ALU.
REQ-012 The block SHALL use one clock and a synchronous, active-high reset, with the ports named `clk` and `rst`.

Function
REQ-013 The block SHALL implement an FSM with three states, IDLE, EXEC and RESP, with one operation outstanding at most.
REQ-014 In IDLE, grant SHALL go to the sole valid requester; when both are valid, the tie SHALL be broken per REQ-026/027.
REQ-015 `req_ready_i` SHALL be high only in IDLE and only for the granted requester; it SHALL depend combinationally on `req_valid_*`.
REQ-016 On acceptance (valid & ready at edge N), the block SHALL register op, funct, operands and owner id, and SHALL move to EXEC.
REQ-017 In EXEC, `alu_op`, `funct`, `alu_a` and `alu_b` SHALL be driven from the registers.
- At edge N+1, `alu_result` and `alu_zero` SHALL be captured into `resp_data` and `resp_zero`.
- The FSM SHALL then move to RESP.
REQ-018 In RESP, `resp_valid_<owner>` SHALL be 1, and the other `resp_valid` SHALL be 0.
- `resp_data` and `resp_zero` SHALL be held stable until the handshake completes.
- Accept-to-response latency SHALL be exactly 2 cycles.
REQ-019 In RESP, when `resp_ready_<owner>` is high, the FSM SHALL move to IDLE at that edge.
- No new request SHALL be accepted in the same cycle; throughput is at most one operation per 3 cycles.
REQ-020 `resp_ready` of the non-owner SHALL be ignored.
REQ-021 Outside EXEC, `alu_op`, `funct`, `alu_a` and `alu_b` SHALL be 0.
REQ-022 Requester inputs changing after acceptance SHALL NOT affect the operation in flight.

Reset
REQ-023 While `rst`=1 at an edge, the FSM SHALL go to IDLE, and `resp_data`, `resp_zero` and all captured registers SHALL go to 0.
- The round-robin pointer SHALL point to requester 0.
REQ-024 Reset asserted in EXEC or RESP SHALL abandon the operation; no response is produced for it.
REQ-025 During reset and in the cycle after it, all `req_ready_*` and `resp_valid_*` SHALL be 0 when `rst`=1, and `req_ready_*` SHALL follow REQ-015 afterwards.

Configuration
REQ-026 With macro `ALU_SHARE_ARB_RR_EN` defined, the tie SHALL be broken round-robin.
- The 1-bit pointer SHALL favour the requester not granted last.
- The pointer SHALL update on every acceptance.
REQ-027 Without `ALU_SHARE_ARB_RR_EN`, requester 0 SHALL always win ties, and no pointer register SHALL exist.

Verification
REQ-028 Reset, then idle: SHALL give all `req_ready`/`resp_valid` = 0 while `rst`=1, with `resp_data`=0.
REQ-029 Requester 0 add: op=00, a=5, b=7, accepted at edge N, with the ALU model returning 12 (zero=0).
- SHALL give `resp_valid_0`=1 after edge N+1, with `resp_data`=12 and `resp_zero`=0.
REQ-030 Requester 1 sub: op=01, a=b=9.
- SHALL give `resp_data`=0 and `resp_zero`=1 at `resp_valid_1`.
- `resp_valid_0` SHALL stay 0.
REQ-031 Both valid every cycle, RR_EN defined, 4 operations: grants SHALL alternate 0,1,0,1.
- Without the macro, grants SHALL be 0,0,0,0.
REQ-032 Backpressure: `resp_ready_0`=0 for 5 cycles in RESP, with `req_valid_1`=1.
- `resp_valid_0` and `resp_data` SHALL hold.
- `req_ready_1` SHALL stay 0 until the cycle after the handshake.
REQ-033 `rst` pulsed in EXEC: SHALL return to IDLE, with no `resp_valid` asserted and the next request served normally.
